// File: rtl/mult_pp_reduce.sv
`default_nettype none
// ============================================================================
//  Module      : mult_pp_reduce
//  Description : Captures a full partial-product array and sums it LANES
//                entries per cycle; returns the unsigned product with a
//                valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================

module mult_pp_reduce #(
    parameter int XLEN     = 32,
    parameter int NrInputs = 32,
    parameter int LANES    = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              en_i,
    input  logic                              flush_i,
    input  logic [NrInputs-1:0][2*XLEN:0]     pp_i,
    input  logic                              pp_valid_i,
    output logic                              pp_ready_o,
    output logic [2*XLEN-1:0]                 product_o,
    output logic                              valid_o,
    input  logic                              ready_i
);

    localparam int PP_W  = 2 * XLEN + 1;
    localparam int IDX_W = (NrInputs > 1) ? $clog2(NrInputs) : 1;

    localparam logic [IDX_W-1:0] C_IDX_STEP = IDX_W'(LANES);
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(NrInputs - LANES);

    generate
        if (((NrInputs % LANES) != 0) || (NrInputs != XLEN)) begin : g_cfg_error
            $error("mult_pp_reduce: NrInputs must equal XLEN and be a multiple of LANES");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                          r_state;
    logic [PP_W-1:0]                 r_acc;
    logic [IDX_W-1:0]                r_idx;
    logic [NrInputs-1:0][PP_W-1:0]   r_buf;
    logic [2*XLEN-1:0]               r_product;
    logic                            r_valid;

    state_t                          w_state_nxt;
    logic [PP_W-1:0]                 w_acc_nxt;
    logic [IDX_W-1:0]                w_idx_nxt;
    logic [2*XLEN-1:0]               w_product_nxt;
    logic                            w_valid_nxt;
    logic                            w_capture;
    logic [PP_W-1:0]                 w_lane_sum;

    // Adder tree over the current group of LANES buffered entries.
    always_comb begin
        w_lane_sum = r_acc;
        for (int k = 0; k < LANES; k++) begin
            w_lane_sum = w_lane_sum + r_buf[r_idx + IDX_W'(k)];
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_acc_nxt     = r_acc;
        w_idx_nxt     = r_idx;
        w_product_nxt = r_product;
        w_valid_nxt   = r_valid;
        w_capture     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (pp_valid_i) begin
                    w_capture   = 1'b1;
                    w_acc_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                w_acc_nxt = w_lane_sum;
                w_idx_nxt = r_idx + C_IDX_STEP;
                if (r_idx == C_IDX_LAST) begin
                    // Bit 2*XLEN of the accumulator is intentionally dropped.
                    w_product_nxt = w_lane_sum[2*XLEN-1:0];
                    w_valid_nxt   = 1'b1;
                    w_state_nxt   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (ready_i) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= ST_IDLE;
            r_acc     <= '0;
            r_idx     <= '0;
            r_buf     <= '0;
            r_product <= '0;
            r_valid   <= 1'b0;
        end else if (flush_i) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
        end else if (en_i) begin
            r_state   <= w_state_nxt;
            r_acc     <= w_acc_nxt;
            r_idx     <= w_idx_nxt;
            r_product <= w_product_nxt;
            r_valid   <= w_valid_nxt;
            if (w_capture) begin
                r_buf <= pp_i;
            end
        end
    end

    assign pp_ready_o = (r_state == ST_IDLE);
    assign product_o  = r_product;
    assign valid_o    = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_mult_pp_reduce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_pp_reduce
//  Description : Self-checking bench for mult_pp_reduce with a behavioural
//                scoreboard, directed scenarios and randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_mult_pp_reduce;

    localparam int XLEN  = 32;
    localparam int NR    = 32;
    localparam int LANES = 4;
    localparam int STEPS = NR / LANES;

    typedef logic [NR-1:0][2*XLEN:0] pp_t;

    logic               clk_i      = 1'b0;
    logic               rst_i      = 1'b0;
    logic               en_i       = 1'b1;
    logic               flush_i    = 1'b0;
    logic               pp_valid_i = 1'b0;
    logic               ready_i    = 1'b1;
    pp_t                pp_i       = '0;
    logic               pp_ready_o;
    logic [2*XLEN-1:0]  product_o;
    logic               valid_o;

    int n_checks = 0;
    int n_fail   = 0;

    mult_pp_reduce #(.XLEN(XLEN), .NrInputs(NR), .LANES(LANES)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (en_i),
        .flush_i    (flush_i),
        .pp_i       (pp_i),
        .pp_valid_i (pp_valid_i),
        .pp_ready_o (pp_ready_o),
        .product_o  (product_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic pp_t mk_ab(input logic [31:0] a, input logic [31:0] b);
        pp_t         p;
        logic [64:0] ax;
        ax = {33'b0, a};
        for (int i = 0; i < NR; i++) p[i] = b[i] ? (ax << i) : 65'd0;
        return p;
    endfunction

    function automatic pp_t mk_raw();
        pp_t p;
        for (int i = 0; i < NR; i++) p[i] = {1'($urandom), $urandom, $urandom};
        return p;
    endfunction

    function automatic logic [63:0] pp_sum(input pp_t p);
        logic [64:0] s;
        s = '0;
        for (int i = 0; i < NR; i++) s = s + p[i];
        return s[63:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an op becomes visible STEPS enabled cycles after capture.
    logic        m_busy  = 1'b0;
    logic        m_valid = 1'b0;
    int          m_cnt   = 0;
    logic [63:0] m_exp   = '0;
    logic [63:0] m_prod  = '0;

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_cnt   <= 0;
            m_prod  <= '0;
        end else if (flush_i) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
        end else if (en_i) begin
            if (!m_busy) begin
                if (pp_valid_i) begin
                    m_busy <= 1'b1;
                    m_cnt  <= 0;
                    m_exp  <= pp_sum(pp_i);
                end
            end else if (m_valid) begin
                if (ready_i) begin
                    m_busy  <= 1'b0;
                    m_valid <= 1'b0;
                end
            end else begin
                m_cnt <= m_cnt + 1;
                if (m_cnt == STEPS - 1) begin
                    m_valid <= 1'b1;
                    m_prod  <= m_exp;
                end
            end
        end
    end

    initial begin
        @(posedge clk_i);
        forever begin
            @(negedge clk_i);
            check("sb_valid",    64'(valid_o),    64'(m_valid));
            check("sb_pp_ready", 64'(pp_ready_o), 64'(!m_busy));
            check("sb_product",  product_o,       m_prod);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_op(input pp_t p);
        pp_i       = p;
        pp_valid_i = 1'b1;
        tick();
        pp_valid_i = 1'b0;
        check("start_pp_ready_low", 64'(pp_ready_o), 64'd0);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!valid_o && n < 200);
        check("wait_valid_timeout", 64'(valid_o), 64'd1);
    endtask

    int          n;
    logic [63:0] held;

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        check("reset_valid",    64'(valid_o),    64'd0);
        check("reset_product",  product_o,       64'd0);
        check("reset_pp_ready", 64'(pp_ready_o), 64'd1);
        rst_i = 1'b1;
        tick();
        check("post_reset_pp_ready", 64'(pp_ready_o), 64'd1);

        // 3 * 5 with latency measurement
        ready_i = 1'b1;
        start_op(mk_ab(32'd3, 32'd5));
        wait_valid(n);
        check("t1_latency", 64'(n + 1), 64'd9);
        check("t1_product", product_o, 64'd15);
        tick();
        check("t1_idle_valid",    64'(valid_o),    64'd0);
        check("t1_idle_pp_ready", 64'(pp_ready_o), 64'd1);

        start_op(mk_ab(32'hFFFF_FFFF, 32'hFFFF_FFFF));
        wait_valid(n);
        check("t2_max_product", product_o, 64'hFFFF_FFFE_0000_0001);
        tick();
        start_op('0);
        wait_valid(n);
        check("t2_zero_product", product_o, 64'd0);
        tick();

        // Backpressure hold
        ready_i = 1'b0;
        start_op(mk_ab(32'd1000, 32'd77));
        wait_valid(n);
        held = product_o;
        check("t3_product", held, 64'd77000);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_hold_valid",    64'(valid_o),    64'd1);
            check("t3_hold_product",  product_o,       held);
            check("t3_hold_pp_ready", 64'(pp_ready_o), 64'd0);
        end
        ready_i = 1'b1;
        tick();
        check("t3_xfer_valid",    64'(valid_o),    64'd0);
        check("t3_xfer_pp_ready", 64'(pp_ready_o), 64'd1);

        // Stall at idx=8
        start_op(mk_ab(32'h1234_5678, 32'h9ABC_DEF0));
        tick();
        tick();
        en_i = 1'b0;
        repeat (3) tick();
        check("t4_stall_valid", 64'(valid_o), 64'd0);
        en_i = 1'b1;
        wait_valid(n);
        check("t4_remaining_edges", 64'(n), 64'd6);
        check("t4_product", product_o, 64'h0B00_EA4E_242D_2080);
        tick();

        // Flush at idx=16, flush with simultaneous offer in IDLE, then 7*9
        start_op(mk_ab(32'hDEAD_BEEF, 32'h1111_1111));
        repeat (4) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("t5_flush_valid",    64'(valid_o),    64'd0);
        check("t5_flush_pp_ready", 64'(pp_ready_o), 64'd1);
        pp_i       = mk_ab(32'd5, 32'd5);
        pp_valid_i = 1'b1;
        flush_i    = 1'b1;
        tick();
        flush_i    = 1'b0;
        pp_valid_i = 1'b0;
        check("t5_flush_no_capture", 64'(pp_ready_o), 64'd1);
        start_op(mk_ab(32'd7, 32'd9));
        wait_valid(n);
        check("t5_product_63", product_o, 64'd63);
        tick();

        ready_i = 1'b0;
        start_op(mk_ab(32'd11, 32'd13));
        wait_valid(n);
        check("t5_done_product", product_o, 64'd143);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        ready_i = 1'b1;
        check("t5_done_flush_valid",    64'(valid_o),    64'd0);
        check("t5_done_flush_pp_ready", 64'(pp_ready_o), 64'd1);

        // Asynchronous reset mid-accumulation
        start_op(mk_ab(32'hFFFF_FFFF, 32'h0000_0003));
        repeat (3) tick();
        #2;
        rst_i = 1'b0;
        #1;
        check("t6_async_valid",    64'(valid_o),    64'd0);
        check("t6_async_product",  product_o,       64'd0);
        check("t6_async_pp_ready", 64'(pp_ready_o), 64'd1);
        #4;
        rst_i = 1'b1;
        tick();
        start_op(mk_ab(32'd2, 32'h8000_0000));
        wait_valid(n);
        check("t6_product", product_o, 64'h1_0000_0000);
        tick();

        // Randomized traffic checked by the scoreboard
        for (int c = 0; c < 4000; c++) begin
            en_i       = ($urandom % 8) != 0;
            ready_i    = ($urandom % 3) != 0;
            pp_valid_i = ($urandom % 4) != 0;
            flush_i    = ($urandom % 64) == 0;
            case ($urandom % 4)
                0:       pp_i = mk_raw();
                1:       pp_i = mk_ab(32'hFFFF_FFFF, $urandom);
                default: pp_i = mk_ab($urandom, $urandom);
            endcase
            tick();
        end
        en_i       = 1'b1;
        ready_i    = 1'b1;
        pp_valid_i = 1'b0;
        flush_i    = 1'b0;
        repeat (20) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mult_pp_reduce.md
Name: mult_pp_reduce

Overview:
- Consumer side of the partial-product interface driven by the multiplier partial-product cell.
- Captures one full array of NrInputs partial products and sums them LANES at a time over several cycles.
- Presents the final unsigned product with a valid/ready output handshake.
- Sits between the partial-product stage and the writeback/result mux of the multiply unit.

Parameters:
XLEN, 32, operand width; partial products are 2*XLEN+1 bits, product is 2*XLEN bits
NrInputs, 32, number of partial products per operation; must equal XLEN
LANES, 4, partial products added per accumulate cycle; NrInputs % LANES == 0, otherwise elaboration error

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-low
en_i  input  1  stage enable; low = stall, all state held
flush_i  input  1  synchronous abort of the current operation
pp_i  input  NrInputs x (2*XLEN+1)  partial-product array
pp_valid_i  input  1  pp_i holds a valid array
pp_ready_o  output  1  block can capture pp_i
product_o  output  2*XLEN  final product
valid_o  output  1  product_o valid
ready_i  input  1  downstream accepts product_o

Behaviour:
- Reset (rst_i=0, async): state=IDLE; acc, idx, capture buffer=0; product_o=0; valid_o=0; pp_ready_o=1 after reset deasserts. Reset mid-operation discards everything.
- Priority on each clock edge: reset > flush_i > ~en_i > normal operation.
- flush_i=1 (en_i don't-care): state=IDLE, acc=0, idx=0, valid_o=0; an input offered in the same cycle is not captured.
- en_i=0 with flush_i=0: all registers hold, including valid_o and product_o. No capture and no output transfer occur, whatever pp_valid_i or ready_i are.
- IDLE state:
  - pp_ready_o=1.
  - If pp_valid_i: copy the whole pp_i array into the buffer, set acc=0, idx=0, go to ACCUM.
  - The producer may change pp_i from the next cycle.
- ACCUM state:
  - pp_ready_o=0.
  - Each cycle: acc <= acc + buf[idx] + ... + buf[idx+LANES-1]; idx <= idx+LANES.
  - The sum is unsigned and 2*XLEN+1 bits wide, wrapping modulo 2^(2*XLEN+1).
  - On the cycle that consumes buf[NrInputs-1], go to DONE.
  - ACCUM lasts NrInputs/LANES cycles (8 at defaults).
- DONE state:
  - valid_o=1; product_o=acc[2*XLEN-1:0]; bit 2*XLEN is dropped.
  - valid_o and product_o stay stable until ready_i=1.
  - Transfer when valid_o & ready_i: go to IDLE with valid_o=0 next cycle.
  - pp_ready_o=0 in DONE, so there is no capture in the transfer cycle.
- Latency: capture at edge N gives valid_o=1 after edge N+NrInputs/LANES (9 edges incl. capture at defaults). Back-to-back throughput is one result per NrInputs/LANES+2 cycles.
- Outputs are registered; there is no combinational path from pp_i to product_o.
- A pp_valid_i drop while in ACCUM/DONE has no effect; the buffer is already captured.

Test Plan:
- Reset, then the array for a=3, b=5 (entries 0 and 2 nonzero: 3, 12) with pp_valid_i=1, ready_i=1 -> pp_ready_o drops next cycle; valid_o=1 with product_o=15 after 9 edges; IDLE one cycle later.
- Array for a=b=0xFFFFFFFF -> product_o=0xFFFFFFFE00000001. Also all-zero array -> product_o=0.
- ready_i=0 for 5 cycles after valid_o rises -> valid_o and product_o hold stable, pp_ready_o=0; ready_i=1 -> transfer, back to IDLE.
- en_i=0 for 3 cycles at ACCUM idx=8 -> acc and idx frozen; result still correct; valid_o is delayed exactly 3 cycles.
- flush_i pulse at ACCUM idx=16, and separately while in DONE -> next cycle IDLE, valid_o=0, pp_ready_o=1; a following operation a=7, b=9 returns 63.
- rst_i asserted mid-ACCUM, asynchronously between edges -> valid_o=0 and product_o=0 immediately. After release, a=2, b=0x80000000 returns 0x100000000.
